// File: rtl/tap_trig.sv
// tap_trig: threshold trigger for an ADC sample stream with edge detect,
// re-arm holdoff, captured trigger sample and a saturating trigger count.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   adc_data/valid  unsigned sample and its qualifier
//   ctl_gt/et/lt    compare-mode enables (OR-ed together)
//   ctl_thr         unsigned threshold
//   ctl_trig_en     trigger enable; low forces IDLE
//   cnt_clr         synchronous clear of trig_cnt
//   trig            one-cycle trigger pulse
//   trig_sample     sample that caused the last trigger
//   trig_cnt        saturating trigger count
//   armed           high while in ARMED
module tap_trig #(
    parameter int DATA_W  = 14,
    parameter int HOLDOFF = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              ctl_gt,
    input  logic              ctl_et,
    input  logic              ctl_lt,
    input  logic [DATA_W-1:0] ctl_thr,
    input  logic              ctl_trig_en,
    input  logic              cnt_clr,
    output logic              trig,
    output logic [DATA_W-1:0] trig_sample,
    output logic [31:0]       trig_cnt,
    output logic              armed
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Holdoff reload value; HOLDOFF=0 bypasses the HOLD state entirely.
    localparam int unsigned HL = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam logic [15:0] HOLD_LOAD = HL[15:0];

    state_t            r_state;
    logic [15:0]       r_hold_cnt;
    logic              r_prev_cond;
    logic              r_trig;
    logic [DATA_W-1:0] r_trig_sample;
    logic [31:0]       r_trig_cnt;

    logic w_cond;
    logic w_edge;
    logic w_fire;

    assign w_cond = (ctl_gt & (adc_data > ctl_thr))
                  | (ctl_et & (adc_data == ctl_thr))
                  | (ctl_lt & (adc_data < ctl_thr));

    assign w_edge = adc_valid & w_cond & ~r_prev_cond;

    assign w_fire = ctl_trig_en & (r_state == S_ARMED) & w_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
            r_prev_cond   <= 1'b0;
            r_trig        <= 1'b0;
            r_trig_sample <= '0;
            r_trig_cnt    <= '0;
        end else begin
            // Edge history tracks the stream in every state.
            if (adc_valid) begin
                r_prev_cond <= w_cond;
            end

            r_trig <= w_fire;

            if (w_fire) begin
                r_trig_sample <= adc_data;
            end

            // A trigger coinciding with a clear counts as the first one.
            if (w_fire) begin
                if (cnt_clr) begin
                    r_trig_cnt <= 32'd1;
                end else if (r_trig_cnt != 32'hFFFF_FFFF) begin
                    r_trig_cnt <= r_trig_cnt + 32'd1;
                end
            end else if (cnt_clr) begin
                r_trig_cnt <= '0;
            end

            if (!ctl_trig_en) begin
                r_state <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (w_edge) begin
                            if (HOLDOFF == 0) begin
                                r_state <= S_ARMED;
                            end else begin
                                r_state    <= S_HOLD;
                                r_hold_cnt <= HOLD_LOAD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == 16'd0) begin
                            r_state <= S_ARMED;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 16'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign trig        = r_trig;
    assign trig_sample = r_trig_sample;
    assign trig_cnt    = r_trig_cnt;
    assign armed       = (r_state == S_ARMED);

endmodule
